booth_seq_ctrl: RTL
===================

BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

Interface
REQ-001 Parameter: N, default 8, operand width in bits; N SHALL be at least 2.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 Port: multiplicand  input  N  signed two's-complement operand M.
REQ-006 Port: multiplier  input  N  signed two's-complement operand Q.
REQ-007 Port: busy  output  1  high from the cycle after start is accepted until the cycle DONE is left.
REQ-008 Port: done  output  1  single-cycle pulse; product is valid while done is high.
REQ-009 Port: product  output  2N  signed product M*Q; holds its value until the next done.

Function
REQ-010 Algorithm: radix-2 Booth, one recoding step per clock, using one internal (N+1)-bit add/subtract datapath shared by all steps.
REQ-011 Registers: accumulator A (N+1 bits, sign-extended), multiplier shift register Q (N bits), Booth bit Q_1 (1 bit), operand register Mreg (N+1 bits, sign-extended), step counter (width ceil(log2(N+1))).
REQ-012 FSM states: IDLE, CALC, DONE.
REQ-013 IDLE with start=1: capture Mreg = sext(multiplicand); set Q = multiplier, A = 0, Q_1 = 0, counter = N; next state CALC.
REQ-014 IDLE with start=0: hold all registers; stay in IDLE.
REQ-015 CALC, one cycle per step: {Q[0],Q_1}=01 gives A+Mreg; 10 gives A-Mreg; 00 or 11 gives A unchanged.
REQ-016 CALC, same cycle: arithmetic right shift of {A_new,Q,Q_1} by 1; A MSB is replicated; counter decrements by 1.
REQ-017 CALC with counter=1: next state DONE; otherwise stay in CALC.
REQ-018 Arithmetic is modulo 2^(N+1) in A; the extra bit guarantees no overflow for all operand pairs, including M = -2^(N-1).
REQ-019 DONE: product <= {A[N-1:0],Q}; done=1 for exactly this one cycle; next state IDLE.
REQ-020 Latency: start accepted at edge t gives done high in the cycle after edge t+N+1; throughput is one multiply per N+2 cycles.
REQ-021 busy=1 in CALC and DONE; busy=0 in IDLE.
REQ-022 start is ignored while in CALC or DONE: no restart and no queuing; operand inputs are don't-care outside the accepting IDLE cycle.
REQ-023 start asserted in the same cycle DONE returns to IDLE is not accepted; it is accepted only if it is still high in a cycle spent in IDLE.
REQ-024 No combinational path from inputs to outputs; all outputs are registered or decoded from state only.

Reset
REQ-025 rst=1 forces, asynchronously: state=IDLE, A=0, Q=0, Q_1=0, Mreg=0, counter=0, product=0, done=0, busy=0.
REQ-026 Reset asserted mid-operation aborts the multiply; no done pulse is generated; product reads 0 afterwards.
REQ-027 After rst deasserts, the first rising edge with start=1 in IDLE begins a new multiply normally.

Verification
REQ-028 N=8: M=3, Q=5, start pulse -> done exactly 10 cycles later (N+2), product=15, busy high for 9 cycles.
REQ-029 M=-128, Q=-128 -> product=16384 (0x4000); M=-128, Q=127 -> product=-16256 (0xC080).
REQ-030 M=0, Q=-1 and M=-1, Q=-1 -> product=0 and product=1 respectively; done is a 1-cycle pulse each time.
REQ-031 start held high continuously with changing operands -> back-to-back results every 10 cycles; each product matches the operands captured at acceptance only.
REQ-032 rst pulsed at step 4 of a multiply -> done stays 0, product=0, busy=0; the next multiply (7 x -6) gives -42.
REQ-033 Random regression: at least 10k signed operand pairs checked against a reference model product.

Source files
------------

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: one recoding step per clock through a
// single (N+1)-bit add/subtract datapath, with an IDLE/CALC/DONE controller.
module booth_seq_ctrl #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N:0]       a_q, a_d;
    logic [N-1:0]     q_q, q_d;
    logic             q1_q, q1_d;
    logic [N:0]       m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   product_q, product_d;
    logic             done_q, done_d;

    logic             op_en_s;
    logic             op_sub_s;
    logic [N:0]       operand_s;
    logic [N:0]       sum_s;
    logic [N:0]       a_new_s;

    // Booth recoding of {Q[0],Q_1} into the shared add/subtract datapath
    always_comb begin
        op_en_s  = 1'b0;
        op_sub_s = 1'b0;
        case ({q_q[0], q1_q})
            2'b01: begin
                op_en_s  = 1'b1;
                op_sub_s = 1'b0;
            end
            2'b10: begin
                op_en_s  = 1'b1;
                op_sub_s = 1'b1;
            end
            default: begin
                op_en_s  = 1'b0;
                op_sub_s = 1'b0;
            end
        endcase
        // Subtraction is A + ~M + 1, so one adder serves both directions.
        operand_s = op_sub_s ? ~m_q : m_q;
        sum_s     = a_q + operand_s + {{N{1'b0}}, op_sub_s};
        if (op_en_s) begin
            a_new_s = sum_s;
        end else begin
            a_new_s = a_q;
        end
    end

    // Controller next-state and register updates
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        q1_d      = q1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = {multiplicand[N-1], multiplicand};
                    q_d     = multiplier;
                    a_d     = '0;
                    q1_d    = 1'b0;
                    cnt_d   = CNT_INIT;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                {a_d, q_d, q1_d} = {a_new_s[N], a_new_s, q_q};
                cnt_d            = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                product_d = {a_q[N-1:0], q_q};
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign product = product_q;

endmodule
